// File: rtl/axi_r_pkg.sv
// Shared types for the AXI R-channel burst arbiter: beat payload and FSM states.
package axi_r_pkg;

    localparam int unsigned R_DATA_WIDTH = 128;
    localparam int unsigned R_ID_WIDTH   = 32;
    localparam int unsigned R_USER_WIDTH = 64;

    typedef struct packed {
        logic [R_ID_WIDTH-1:0]   id;
        logic [R_DATA_WIDTH-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [R_USER_WIDTH-1:0] user;
    } r_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } r_arb_state_t;

endpackage

// File: rtl/r_rr_pick.sv
// Two-way round-robin selector: on contention the source that was not served last wins.
module r_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_r_burst_arbiter.sv
// Two-to-one AXI R-channel arbiter: grant held for a whole burst, round-robin between
// bursts, runaway bursts cut off after BURST_LEN beats with a sticky error flag.
module axi_r_burst_arbiter
    import axi_r_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 32,
    parameter int unsigned USER_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   S0_rid,
    input  logic [DATA_WIDTH-1:0] S0_rdata,
    input  logic [1:0]            S0_rresp,
    input  logic                  S0_rlast,
    input  logic [USER_WIDTH-1:0] S0_ruser,
    input  logic                  S0_rvalid,
    output logic                  S0_rready,
    input  logic [ID_WIDTH-1:0]   S1_rid,
    input  logic [DATA_WIDTH-1:0] S1_rdata,
    input  logic [1:0]            S1_rresp,
    input  logic                  S1_rlast,
    input  logic [USER_WIDTH-1:0] S1_ruser,
    input  logic                  S1_rvalid,
    output logic                  S1_rready,
    output logic [ID_WIDTH-1:0]   M_rid,
    output logic [DATA_WIDTH-1:0] M_rdata,
    output logic [1:0]            M_rresp,
    output logic                  M_rlast,
    output logic [USER_WIDTH-1:0] M_ruser,
    output logic                  M_rvalid,
    input  logic                  M_rready,
    output logic [1:0]            grant,
    output logic                  err_overrun
);

    localparam int unsigned    CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BURST_LEN - 1);

    r_arb_state_t     state;
    logic             last;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       pick;
    logic             src_last;
    logic             at_limit;
    logic             beat;

    r_rr_pick u_pick (
        .req  ({S1_rvalid, S0_rvalid}),
        .last (last),
        .pick (pick)
    );

    // Zero-latency pass-through of the granted source; everything parks at 0 in IDLE.
    always_comb begin
        M_rid     = '0;
        M_rdata   = '0;
        M_rresp   = '0;
        M_ruser   = '0;
        M_rvalid  = 1'b0;
        S0_rready = 1'b0;
        S1_rready = 1'b0;
        src_last  = 1'b0;
        case (state)
            GRANT0: begin
                M_rid     = S0_rid;
                M_rdata   = S0_rdata;
                M_rresp   = S0_rresp;
                M_ruser   = S0_ruser;
                M_rvalid  = S0_rvalid;
                S0_rready = M_rready;
                src_last  = S0_rlast;
            end
            GRANT1: begin
                M_rid     = S1_rid;
                M_rdata   = S1_rdata;
                M_rresp   = S1_rresp;
                M_ruser   = S1_ruser;
                M_rvalid  = S1_rvalid;
                S1_rready = M_rready;
                src_last  = S1_rlast;
            end
            default: ;
        endcase
        at_limit = (state != IDLE) && (beat_cnt == LIMIT);
        M_rlast  = src_last | at_limit;
        beat     = M_rvalid & M_rready;
    end

    // Arbitration FSM; a beat carrying M_rlast (real or forced) ends the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
            grant       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[0]) begin
                        state <= GRANT0;
                        grant <= 2'b01;
                    end else if (pick[1]) begin
                        state <= GRANT1;
                        grant <= 2'b10;
                    end
                end
                GRANT0, GRANT1: begin
                    if (beat) begin
                        if (M_rlast) begin
                            state    <= IDLE;
                            grant    <= 2'b00;
                            last     <= (state == GRANT1);
                            beat_cnt <= '0;
                            if (!src_last) begin
                                err_overrun <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_r_burst_arbiter.sv
// Directed self-checking bench for axi_r_burst_arbiter with hand-computed expectations.
module tb_axi_r_burst_arbiter;

    logic         clk;
    logic         reset;
    logic [31:0]  S0_rid,   S1_rid,   M_rid;
    logic [127:0] S0_rdata, S1_rdata, M_rdata;
    logic [1:0]   S0_rresp, S1_rresp, M_rresp;
    logic         S0_rlast, S1_rlast, M_rlast;
    logic [63:0]  S0_ruser, S1_ruser, M_ruser;
    logic         S0_rvalid, S1_rvalid, M_rvalid;
    logic         S0_rready, S1_rready, M_rready;
    logic [1:0]   grant;
    logic         err_overrun;

    int n_checks;
    int n_errors;

    axi_r_burst_arbiter #(
        .DATA_WIDTH (128),
        .ID_WIDTH   (32),
        .USER_WIDTH (64),
        .BURST_LEN  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .S0_rid      (S0_rid),
        .S0_rdata    (S0_rdata),
        .S0_rresp    (S0_rresp),
        .S0_rlast    (S0_rlast),
        .S0_ruser    (S0_ruser),
        .S0_rvalid   (S0_rvalid),
        .S0_rready   (S0_rready),
        .S1_rid      (S1_rid),
        .S1_rdata    (S1_rdata),
        .S1_rresp    (S1_rresp),
        .S1_rlast    (S1_rlast),
        .S1_ruser    (S1_ruser),
        .S1_rvalid   (S1_rvalid),
        .S1_rready   (S1_rready),
        .M_rid       (M_rid),
        .M_rdata     (M_rdata),
        .M_rresp     (M_rresp),
        .M_rlast     (M_rlast),
        .M_ruser     (M_ruser),
        .M_rvalid    (M_rvalid),
        .M_rready    (M_rready),
        .grant       (grant),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven, outputs checked #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int hs;
        int s0_n;
        int s1_n;
        int ph;
        int b;
        logic [1:0] bp [5];

        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        S0_rid    = '0; S0_rdata = '0; S0_rresp = '0; S0_rlast = 1'b0; S0_ruser = '0;
        S1_rid    = '0; S1_rdata = '0; S1_rresp = '0; S1_rlast = 1'b0; S1_ruser = '0;
        S0_rvalid = 1'b1;
        S1_rvalid = 1'b1;
        M_rready  = 1'b1;

        // Reset hold with both sources requesting
        cyc(); cyc();
        #1;
        check("rst_grant",  128'(grant),       128'(2'b00));
        check("rst_mvalid", 128'(M_rvalid),    128'(0));
        check("rst_s0rdy",  128'(S0_rready),   128'(0));
        check("rst_s1rdy",  128'(S1_rready),   128'(0));
        check("rst_err",    128'(err_overrun), 128'(0));
        check("rst_mdata",  128'(M_rdata),     128'(0));

        // S0 alone, 4-beat burst
        cyc();
        reset = 1'b0; S1_rvalid = 1'b0;
        S0_rdata = 128'(100); S0_rlast = 1'b0; S0_rid = 32'h5; S0_rresp = 2'b01; S0_ruser = 64'h7;
        #1;
        check("s0_bubble_grant",  128'(grant),    128'(2'b00));
        check("s0_bubble_mvalid", 128'(M_rvalid), 128'(0));
        for (int i = 0; i < 4; i++) begin
            cyc();
            S0_rdata = 128'(100 + i);
            S0_rlast = (i == 3);
            #1;
            check("s0_grant",  128'(grant),     128'(2'b01));
            check("s0_mvalid", 128'(M_rvalid),  128'(1));
            check("s0_mdata",  M_rdata,         128'(100 + i));
            check("s0_mlast",  128'(M_rlast),   128'(i == 3));
            check("s0_s1rdy",  128'(S1_rready), 128'(0));
        end
        check("s0_rid",   128'(M_rid),   128'(32'h5));
        check("s0_rresp", 128'(M_rresp), 128'(2'b01));
        check("s0_ruser", 128'(M_ruser), 128'(64'h7));
        cyc();
        S0_rvalid = 1'b0;
        #1;
        check("s0_end_grant", 128'(grant),   128'(2'b00));
        check("s0_end_mdata", M_rdata,       128'(0));
        check("s0_end_mlast", 128'(M_rlast), 128'(0));

        // Both sources streaming 2-beat bursts: S0,S1,S0,S1 with a bubble between
        reset = 1'b1;
        s0_n = 0; s1_n = 0;
        S0_rvalid = 1'b1; S1_rvalid = 1'b1; M_rready = 1'b1;
        S0_rdata = 128'(200); S0_rlast = 1'b0;
        S1_rdata = 128'(300); S1_rlast = 1'b0;
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            S0_rdata = 128'(200 + s0_n); S0_rlast = s0_n[0];
            S1_rdata = 128'(300 + s1_n); S1_rlast = s1_n[0];
            ph = c % 3;
            b  = c / 3;
            #1;
            if (ph == 0) begin
                check("rr_idle_grant",  128'(grant),    128'(2'b00));
                check("rr_idle_mvalid", 128'(M_rvalid), 128'(0));
            end else if (b % 2 == 0) begin
                check("rr_s0_grant", 128'(grant),     128'(2'b01));
                check("rr_s0_mdata", M_rdata,         128'(200 + s0_n));
                check("rr_s0_mlast", 128'(M_rlast),   128'(ph == 2));
                check("rr_s0_s1rdy", 128'(S1_rready), 128'(0));
                s0_n++;
            end else begin
                check("rr_s1_grant", 128'(grant),     128'(2'b10));
                check("rr_s1_mdata", M_rdata,         128'(300 + s1_n));
                check("rr_s1_mlast", 128'(M_rlast),   128'(ph == 2));
                check("rr_s1_s0rdy", 128'(S0_rready), 128'(0));
                s1_n++;
            end
        end

        // S1 3-beat burst under backpressure 1,0,0,1,1
        bp[0] = 1'b1; bp[1] = 1'b0; bp[2] = 1'b0; bp[3] = 1'b1; bp[4] = 1'b1;
        cyc();
        S0_rvalid = 1'b0;
        S1_rvalid = 1'b1; S1_rdata = 128'(400); S1_rlast = 1'b0;
        S1_rid = 32'h9; S1_rresp = 2'b10; S1_ruser = 64'h33;
        #1;
        check("bp_idle_grant", 128'(grant), 128'(2'b00));
        k = 0; hs = 0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            M_rready = bp[j][0];
            S1_rdata = 128'(400 + k);
            S1_rlast = (k == 2);
            #1;
            check("bp_grant",  128'(grant),     128'(2'b10));
            check("bp_mdata",  M_rdata,         128'(400 + k));
            check("bp_mlast",  128'(M_rlast),   128'(k == 2));
            check("bp_s1rdy",  128'(S1_rready), 128'(bp[j][0]));
            check("bp_s0rdy",  128'(S0_rready), 128'(0));
            if (M_rvalid && M_rready) hs++;
            if (bp[j][0]) k++;
        end
        check("bp_rid",   128'(M_rid),   128'(32'h9));
        check("bp_rresp", 128'(M_rresp), 128'(2'b10));
        check("bp_ruser", 128'(M_ruser), 128'(64'h33));
        check("bp_beats", 128'(hs),      128'(3));
        cyc();
        S1_rvalid = 1'b0;
        M_rready  = 1'b1;
        #1;
        check("bp_end_grant", 128'(grant), 128'(2'b00));

        // Runaway S1 burst: 10 beats with no rlast
        cyc();
        S1_rvalid = 1'b1; S1_rdata = 128'(500); S1_rlast = 1'b0;
        #1;
        check("ov_idle_grant", 128'(grant), 128'(2'b00));
        for (int i = 0; i < 8; i++) begin
            cyc();
            S1_rdata = 128'(500 + i);
            #1;
            check("ov_grant", 128'(grant),       128'(2'b10));
            check("ov_mdata", M_rdata,           128'(500 + i));
            check("ov_mlast", 128'(M_rlast),     128'(i == 7));
            check("ov_err",   128'(err_overrun), 128'(0));
        end
        cyc();
        S1_rdata = 128'(508);
        #1;
        check("ov_bubble_grant", 128'(grant),       128'(2'b00));
        check("ov_bubble_err",   128'(err_overrun), 128'(1));
        for (int i = 8; i < 10; i++) begin
            cyc();
            S1_rdata = 128'(500 + i);
            #1;
            check("ov2_grant", 128'(grant),       128'(2'b10));
            check("ov2_mdata", M_rdata,           128'(500 + i));
            check("ov2_mlast", 128'(M_rlast),     128'(0));
            check("ov2_err",   128'(err_overrun), 128'(1));
        end
        cyc();
        S1_rvalid = 1'b0;
        #1;
        check("ov_hold_grant", 128'(grant),       128'(2'b10));
        check("ov_hold_err",   128'(err_overrun), 128'(1));

        // Reset during beat 2 of an S0 burst, then replay it
        reset = 1'b1;
        S0_rvalid = 1'b1; S0_rdata = 128'(600); S0_rlast = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        check("mr_rst_grant", 128'(grant),       128'(2'b00));
        check("mr_rst_err",   128'(err_overrun), 128'(0));
        cyc();
        #1;
        check("mr_b0_mdata", M_rdata, 128'(600));
        cyc();
        S0_rdata = 128'(601);
        #1;
        check("mr_b1_mdata", M_rdata, 128'(601));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        S0_rdata = 128'(600);
        #1;
        check("mr_after_grant",  128'(grant),     128'(2'b00));
        check("mr_after_mvalid", 128'(M_rvalid),  128'(0));
        check("mr_after_s0rdy",  128'(S0_rready), 128'(0));
        for (int i = 0; i < 4; i++) begin
            cyc();
            S0_rdata = 128'(600 + i);
            S0_rlast = (i == 3);
            #1;
            check("mr_grant", 128'(grant),   128'(2'b01));
            check("mr_mdata", M_rdata,       128'(600 + i));
            check("mr_mlast", 128'(M_rlast), 128'(i == 3));
        end
        cyc();
        S0_rvalid = 1'b0;
        #1;
        check("mr_end_grant", 128'(grant),       128'(2'b00));
        check("mr_end_err",   128'(err_overrun), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_r_burst_arbiter.md
# axi_r_burst_arbiter

Two-to-one arbiter for the AXI read-data (R) channel. Two upstream R sources share one downstream R consumer. The grant is locked for a whole burst, released on the `rlast` handshake, and sources are chosen round-robin. It sits where a single stream-side R path must be shared between two memory-side masters. A beat-count guard detects and terminates runaway bursts that never assert `rlast`.

## Interface
Parameters:
- `DATA_WIDTH`, 128: R data width.
- `ID_WIDTH`, 32: `rid` width.
- `USER_WIDTH`, 64: `ruser` width.
- `BURST_LEN`, 8: maximum beats per burst before forced termination; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `S0_rid / S0_rdata / S0_rresp / S0_rlast / S0_ruser`  in  ID_WIDTH / DATA_WIDTH / 2 / 1 / USER_WIDTH  source 0 beat.
- `S0_rvalid`  in  1; `S0_rready`  out  1  source 0 handshake.
- `S1_*`  same set and directions as `S0_*`  source 1.
- `M_rid / M_rdata / M_rresp / M_rlast / M_ruser / M_rvalid`  out  widths as above  merged output.
- `M_rready`  in  1  downstream ready.
- `grant`  out  2  one-hot current owner: `01` = S0, `10` = S1, `00` = idle.
- `err_overrun`  out  1  sticky; set on a forced burst termination.

## Operation
- FSM states:
  - IDLE, GRANT0, GRANT1.
  - Reset enters IDLE and clears the beat counter and `err_overrun`.
  - Reset sets the round-robin pointer `last` = 1, so S0 wins the first contention.
- IDLE:
  - No source is connected.
  - `M_rvalid`=0; `S0_rready`=`S1_rready`=0.
  - Sampling only S0 valid → GRANT0; only S1 → GRANT1.
  - Both valid → grant the source ≠ `last`.
  - Neither → stay in IDLE.
- GRANTn:
  - `M_*` mirror `Sn_*` combinationally; `Sn_rready` = `M_rready`.
  - The non-granted source sees `rready` = 0.
  - A beat is a cycle with `M_rvalid & M_rready`.
  - Each beat increments `beat_cnt` (width `$clog2(BURST_LEN+1)`).
- Burst end:
  - A beat with `Sn_rlast`=1 → IDLE, `last`=n, `beat_cnt`=0.
- Overrun:
  - Applies to the beat with `beat_cnt` == BURST_LEN−1 that arrives with `Sn_rlast`=0.
  - On that beat `M_rlast` is forced to 1 and `err_overrun` is set.
  - The FSM then goes to IDLE with `last`=n.
  - Remaining beats from that source are arbitrated as a new burst.
- `err_overrun` clears only on `reset`.
- `rresp`, `rid` and `ruser` pass through unmodified.
- Outputs after reset: `M_rvalid`=0, `S0_rready`=`S1_rready`=0, `grant`=`00`, `err_overrun`=0. `M_rdata/rid/ruser/rresp/rlast` are 0 while in IDLE.

## Timing
- Arbitration costs one registered cycle: valid sampled in IDLE at edge k → `M_rvalid` may be high from cycle k+1.
- One idle bubble follows every burst (the `rlast` beat → IDLE → next grant).
- While granted, latency is zero (combinational pass-through). `M_rready`→`Sn_rready` is a combinational path.
- AXI stability holds by construction: the granted source's payload is held while `valid & !ready`, and the grant never changes mid-beat.
- Simultaneous requests go to the source ≠ `last`. A request arriving during another's burst waits, and cannot be starved beyond one burst of at most BURST_LEN beats.
- Reset mid-burst: the next cycle is IDLE with all outputs at reset values. The in-flight burst is abandoned, with no recovery.
- BURST_LEN=1: every beat terminates the burst; non-`rlast` beats set `err_overrun`.

## Structure
- Shared package `axi_r_pkg`:
  - typedef `r_beat_t` (struct of id, data, resp, last, user), parameterised through package localparams mirroring the defaults;
  - `enum {IDLE, GRANT0, GRANT1} r_arb_state_t`.
- One sub-module, `r_rr_pick`: a two-way round-robin selector (inputs: req[1:0], last; output: one-hot pick). The FSM, counter and mux stay in the top module.

## Test plan
- Reset hold: drive both sources valid during reset → `grant`=`00`, `M_rvalid`=0, both `rready`=0, `err_overrun`=0.
- S0 alone, 4-beat burst with `rlast` on beat 4, `M_rready`=1 → one bubble, then 4 consecutive beats, `M_rlast` on the 4th, `grant` back to `00` the next cycle.
- Both sources continuously presenting 2-beat bursts → grant order S0, S1, S0, S1, with one idle cycle between bursts; `S1_rready`=0 throughout every S0 burst.
- Backpressure: `M_rready` pattern 1,0,0,1,1 during an S1 3-beat burst → `M_*` stable while stalled, exactly 3 beats transferred, `S0_rready` stays 0.
- Overrun: S1 sends 10 beats with `rlast`=0, BURST_LEN=8 → `M_rlast`=1 on beat 8, `err_overrun`=1 and stays high; beats 9–10 are granted as a new burst after the bubble.
- Reset at beat 2 of a 4-beat S0 burst → the next cycle shows `grant`=`00` and `M_rvalid`=0; S0 re-presents the burst and it completes normally.
